// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the piso_tx8 serial transmitter.
//   tx_state_t  : transmitter FSM states (PARITY exists only when the
//                 PISO_TX8_PARITY_EN macro is defined)
//   SDO_IDLE    : line level while no frame is in progress
//   START_BIT   : level of the start bit
//   STOP_BIT    : level of the stop bit
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PISO_TX8_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  localparam logic SDO_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: WIDTH-bit parallel-load / serial-shift register.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-high clear
//   load   : capture din (has priority over shift)
//   shift  : move the next bit into the output position
//   din    : parallel word
//   sbit   : bit currently at the output end (d[0] side when LSB_FIRST=1,
//            d[WIDTH-1] side otherwise)
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sbit
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      if (LSB_FIRST) q <= {1'b0, q[WIDTH-1:1]};
      else           q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign sbit = LSB_FIRST ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/piso_tx8.sv
// piso_tx8: parallel-in / serial-out frame transmitter.
// Frame on sdo: start bit (0), WIDTH data bits, optional even-parity bit,
// stop bit (1). A word is accepted via d_valid/d_ready on any clock edge
// while idle; afterwards the frame advances one bit per clock where en=1.
// Optional feature: define PISO_TX8_PARITY_EN to insert the parity bit.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous active-high reset
//   en      : bit-rate tick
//   d_valid : word on d is offered
//   d       : parallel data word (WIDTH bits)
//   d_ready : transmitter can accept a word
//   sdo     : serial data out, idles high
//   busy    : frame in progress
//   done    : one-clock pulse when the stop bit completes
module piso_tx8
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             d_ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          sdo_nx, busy_nx, ready_nx, done_nx;
  logic          load, shift, sbit;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (d),
    .sbit  (sbit)
  );

`ifdef PISO_TX8_PARITY_EN
  // Parity is taken from the word as accepted, since the shift register
  // no longer holds the full word by the time the parity bit is sent.
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset)     par_q <= 1'b0;
    else if (load) par_q <= ^d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sdo     <= SDO_IDLE;
      busy    <= 1'b0;
      d_ready <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sdo     <= sdo_nx;
      busy    <= busy_nx;
      d_ready <= ready_nx;
      done    <= done_nx;
    end
  end

  // cnt is the index of the data bit currently on sdo while in DATA.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sdo_nx   = sdo;
    busy_nx  = busy;
    ready_nx = d_ready;
    done_nx  = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;

    case (state)
      IDLE: begin
        // Accept does not wait for en; the start bit then lasts until
        // the next en tick.
        if (d_valid && d_ready) begin
          load     = 1'b1;
          cnt_nx   = '0;
          state_nx = START;
          sdo_nx   = START_BIT;
          busy_nx  = 1'b1;
          ready_nx = 1'b0;
        end
      end
      START: begin
        if (en) begin
          state_nx = DATA;
          sdo_nx   = sbit;
          shift    = 1'b1;
        end
      end
      DATA: begin
        if (en) begin
          if (cnt == CNT_LAST) begin
`ifdef PISO_TX8_PARITY_EN
            state_nx = PARITY;
            sdo_nx   = par_q;
`else
            state_nx = STOP;
            sdo_nx   = STOP_BIT;
`endif
          end else begin
            sdo_nx = sbit;
            shift  = 1'b1;
            cnt_nx = cnt + CW'(1);
          end
        end
      end
`ifdef PISO_TX8_PARITY_EN
      PARITY: begin
        if (en) begin
          state_nx = STOP;
          sdo_nx   = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (en) begin
          state_nx = IDLE;
          sdo_nx   = SDO_IDLE;
          busy_nx  = 1'b0;
          ready_nx = 1'b1;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        sdo_nx   = SDO_IDLE;
        busy_nx  = 1'b0;
        ready_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/piso_tx8.md
Name: piso_tx8

Overview:
- Parallel-in/serial-out transmitter. It is the read-out side for the team's 8-bit parallel-load registers.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per enable tick.
- Each frame is: start bit, data bits, optional parity bit, stop bit.
- Sits between the register bank and a single-wire serial link, or a downstream deserializer.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..16.
- LSB_FIRST, 1: 1 sends d[0] first; 0 sends d[WIDTH-1] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- en  input  1  bit-rate tick; the FSM advances only on edges where en=1.
- d_valid  input  1  the word on d is offered.
- d  input  WIDTH  parallel data word.
- d_ready  output  1  the transmitter can accept a word.
- sdo  output  1  serial data out; idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, sdo=1, d_ready=1, busy=0, done=0, shift register=0, bit counter=0.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP. All outputs are registered.
- IDLE: d_ready=1, sdo=1, busy=0.
  - Accept occurs on an edge with d_valid=1 and d_ready=1. It is independent of en.
  - On accept: d is captured into the shift register, the counter clears, state=START, sdo=0, busy=1, d_ready=0.
  - d_valid=1 on an edge where d_ready=0 is ignored. No word is lost by the transmitter; the upstream must hold d_valid.
- START: on the next en edge, state=DATA and sdo=first data bit.
- DATA: on each en edge the next bit is presented and the counter increments.
  - After bit WIDTH-1 has been held for one tick, the next en edge moves to PARITY if enabled, otherwise to STOP.
  - STOP drives sdo=1.
- STOP: on the next en edge, state=IDLE, done=1 for exactly one clk cycle, busy=0, d_ready=1.
- Frame length in en ticks: WIDTH+2 without parity, WIDTH+3 with parity. Each bit is held from one en edge to the next.
- en=0: state, counter and sdo hold indefinitely. en stuck at 1 gives one bit per clk.
- d may change after accept with no effect on the frame in flight.
- Minimum spacing between frames: one clk cycle in IDLE. The accept may coincide with the done cycle; d_ready is already 1 then.
- reset asserted mid-frame takes priority over en and d_valid.
  - Next cycle: IDLE with sdo=1 and no done pulse.
  - The aborted word is discarded.
- Counter is ceil(log2(WIDTH)) bits. It never wraps within a frame and clears on accept.

Optional Feature:
- Macro: PISO_TX8_PARITY_EN.
- Defined: adds the PARITY state after DATA. sdo equals the XOR of the captured WIDTH bits (even parity), so the frame is WIDTH+3 ticks.
- Undefined: no PARITY state and no parity logic. The frame is WIDTH+2 ticks.

Decomposition:
- Shared package piso_pkg holds:
  - the state enum typedef tx_state_t;
  - constants SDO_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One natural sub-module: piso_shreg. It is the WIDTH-bit load/shift register with load, shift and LSB_FIRST direction, and it exposes the current output bit.
- The FSM, counter and parity logic stay in the top module.

Test Plan:
- Reset, then d=0xA5, d_valid=1 for one cycle, en=1 every clk, LSB_FIRST=1 -> sdo sequence 0,1,0,1,0,0,1,0,1,1. done pulses once on the edge after the stop bit; d_ready=0 for exactly 10 cycles.
- Same word with LSB_FIRST=0 -> sdo 0,1,0,1,0,0,1,0,1,1 (0xA5 is a bit-palindrome, so the sequence is unchanged). Then d=0x81 -> sdo 0,1,0,0,0,0,0,0,1,1 in both orders. Then d=0x01 -> LSB_FIRST=1 gives data 1,0,0,0,0,0,0,0; LSB_FIRST=0 gives data 0,0,0,0,0,0,0,1.
- en pulsed once every 4 clk with d=0x3C -> each bit held exactly 4 clk; d changed to 0xFF mid-frame -> no effect on the sdo sequence.
- Second word offered with d_valid held high during frame 1 -> accepted on the first IDLE cycle; exactly one done per frame; no word dropped or duplicated.
- reset pulsed during DATA bit 3 -> next cycle sdo=1, busy=0, d_ready=1, done=0. A fresh 0x55 frame then transmits correctly.
- With PISO_TX8_PARITY_EN: d=0x07 -> parity bit 1; d=0x03 -> parity bit 0. Frame is 11 ticks, and done is delayed by one tick.
